// File: rtl/dsm_bitstream_modulator_if.sv
// Sample stream into the delta-sigma modulator.
//   sample_in    : signed two's-complement sample (DATA_W bits)
//   sample_valid : source has a sample on sample_in
//   sample_ready : modulator buffer is empty and will take the sample
// master = sample source, slave = modulator.
interface dsm_bitstream_modulator_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/dsm_bitstream_modulator.sv
// Second-order delta-sigma modulator: turns a stream of signed samples into
// a 1-bit pulse-density stream at clock rate. Each sample is held for OSR
// clocks. A one-deep buffer paces samples; frame_strobe marks the last clock
// of each frame (same cadence as the matching decimator's output clock).
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : 1 = modulate, 0 = idle (integrators cleared, buffer kept)
//   smp          : sample stream (valid/ready), slave side
//   bit_out      : registered bitstream
//   frame_strobe : pulse on the last clock of each running frame
//   underrun     : pulse with frame_strobe when no new sample is buffered
module dsm_bitstream_modulator #(
    parameter int DATA_W = 16,
    parameter int OSR    = 64,
    parameter int ACC_W  = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    dsm_bitstream_modulator_if.slave   smp,
    output logic                       bit_out,
    output logic                       frame_strobe,
    output logic                       underrun
);
    localparam int CNT_W = $clog2(OSR);
    localparam int SUM_W = ACC_W + 2;

    localparam logic signed [SUM_W-1:0] FS     = SUM_W'(1) << (DATA_W - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI = (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  i1, i2;
    logic signed [DATA_W-1:0] active;
    logic signed [DATA_W-1:0] buf_data;
    logic                     buf_full;

    logic                     xfer, last, load;
    logic                     y;
    logic signed [SUM_W-1:0]  x_w, i1_w, i2_w, v_w, sum1, sum2;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI)      return SAT_HI[ACC_W-1:0];
        else if (v < SAT_LO) return SAT_LO[ACC_W-1:0];
        else                 return v[ACC_W-1:0];
    endfunction

    // Ready is judged on the buffer state before any same-clock consumption.
    assign smp.sample_ready = !buf_full;
    assign xfer             = smp.sample_valid && !buf_full;

    // Frame end only counts while enabled; dropping en aborts the frame.
    assign last         = (state == RUN) && en && (cnt == CNT_W'(OSR - 1));
    assign frame_strobe = last;
    assign underrun     = last && !buf_full;
    assign load         = en && buf_full && (state != RUN);

    always_comb begin
        x_w  = {{(SUM_W - DATA_W){active[DATA_W-1]}}, active};
        i1_w = SUM_W'(i1);
        i2_w = SUM_W'(i2);
        y    = !i2[ACC_W-1];
        v_w  = y ? FS : -FS;
        sum1 = i1_w + x_w - v_w;
        // uses pre-update i1
        sum2 = i2_w + i1_w - (v_w <<< 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            i1       <= '0;
            i2       <= '0;
            active   <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            bit_out  <= 1'b0;
        end else begin
            if (load || (last && buf_full)) buf_full <= 1'b0;
            if (xfer) begin
                buf_data <= smp.sample_in;
                buf_full <= 1'b1;
            end

            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                i1      <= '0;
                i2      <= '0;
                bit_out <= ~bit_out;
            end else begin
                case (state)
                    IDLE, PRIME: begin
                        cnt <= '0;
                        i1  <= '0;
                        i2  <= '0;
                        // IDLE idles at mid-scale; PRIME freezes the line
                        if (state == IDLE) bit_out <= ~bit_out;
                        if (buf_full) begin
                            state  <= RUN;
                            active <= buf_data;
                        end else begin
                            state  <= PRIME;
                        end
                    end
                    RUN: begin
                        cnt     <= cnt + 1'b1;   // OSR is a power of two: wraps
                        i1      <= sat(sum1);
                        i2      <= sat(sum2);
                        bit_out <= y;
                        if (last && buf_full) active <= buf_data;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dsm_bitstream_modulator.sv
module tb_dsm_bitstream_modulator;
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic bit_out, frame_strobe, underrun;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [15:0] q[$];
    int acc_idx[$];

    dsm_bitstream_modulator_if #(.DATA_W(16)) sif ();

    dsm_bitstream_modulator #(.DATA_W(16), .OSR(64), .ACC_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .smp          (sif),
        .bit_out      (bit_out),
        .frame_strobe (frame_strobe),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One 64-clock frame, entered at counter 0. Samples in q are offered
    // from iteration 'start' on; accepted iterations go to acc_idx.
    task automatic run_frame(input int start, output int ones, output int s_at,
                             output int s_n, output int u_at, output int u_n,
                             output int rdy_low);
        logic xf;
        ones = 0; s_at = -1; s_n = 0; u_at = -1; u_n = 0; rdy_low = 0;
        acc_idx.delete();
        for (int k = 0; k < 64; k++) begin
            if (k >= start && q.size() > 0) begin
                sif.sample_valid = 1'b1;
                sif.sample_in    = q[0];
            end else begin
                sif.sample_valid = 1'b0;
            end
            if (frame_strobe) begin s_n++; s_at = k; end
            if (underrun)     begin u_n++; u_at = k; end
            if (!sif.sample_ready) rdy_low++;
            xf = sif.sample_valid && sif.sample_ready;
            tick();
            if (xf) begin
                void'(q.pop_front());
                acc_idx.push_back(k);
            end
            if (bit_out) ones++;
        end
        sif.sample_valid = 1'b0;
    endtask

    int ones, s_at, s_n, u_at, u_n, rdy_low;
    logic b;
    int zbits[4]  = '{1, 0, 0, 1};
    int zi2[4]    = '{-65536, -32768, 32768, 0};

    initial begin
        rst_n = 1'b0; en = 1'b0;
        sif.sample_valid = 1'b0; sif.sample_in = '0;
        tick(); tick(); tick();

        // reset state
        check("rst_bit_out", bit_out, 0);
        check("rst_ready", sif.sample_ready, 1);
        check("rst_strobe", frame_strobe, 0);
        check("rst_underrun", underrun, 0);

        // idle mid-scale toggling
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("idle_toggle_%0d", k), bit_out, (k % 2 == 0) ? 1 : 0);
        end

        // zero input: load in IDLE, then enable
        sif.sample_in = 16'sd0; sif.sample_valid = 1'b1;
        tick();
        sif.sample_valid = 1'b0;
        check("load_ready_low", sif.sample_ready, 0);
        en = 1'b1;
        tick();                                  // IDLE -> RUN, counter 0
        check("run_ready_high", sif.sample_ready, 1);
        check("run_i2_start", dut.i2, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("zero_bit_%0d", k), bit_out, zbits[k % 4]);
            if (k < 4) check($sformatf("zero_i2_%0d", k), dut.i2, zi2[k]);
        end
        for (int k = 0; k < 55; k++) tick();     // counter now 63
        check("f1_strobe", frame_strobe, 1);
        check("f1_underrun", underrun, 1);
        tick();

        // F2: active 0; 16384 arrives at frame start
        q.push_back(16'sd16384);
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check("f2_ones", ones, 32);
        check("f2_strobe_n", s_n, 1);
        check("f2_strobe_at", s_at, 63);
        check("f2_underrun_n", u_n, 0);
        check("f2_acc_n", acc_idx.size(), 1);

        // F3: two back-to-back samples; second must wait for consumption
        q.push_back(16'sd16384);
        q.push_back(-16'sd16384);
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check("f3_acc_n", acc_idx.size(), 1);
        check("f3_acc_at", acc_idx[0], 0);
        check("f3_ready_low", rdy_low, 63);
        check("f3_pending", q.size(), 1);

        // F4: steady +16384, pending -16384 lands at frame start
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check_range("f4_ones_pos_half", ones, 46, 50);
        check("f4_acc_n", acc_idx.size(), 1);
        check("f4_acc_at", acc_idx[0], 0);
        check("f4_underrun_n", u_n, 0);

        // F5: active -16384, buffer empty; sample offered only on strobe clock
        q.push_back(16'sd32767);
        run_frame(63, ones, s_at, s_n, u_at, u_n, rdy_low);
        check("f5_underrun_n", u_n, 1);
        check("f5_underrun_at", u_at, 63);
        check("f5_strobe_at", s_at, 63);
        check("f5_acc_n", acc_idx.size(), 1);
        check("f5_acc_at", acc_idx[0], 63);

        // F6: -16384 reused after underrun
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check_range("f6_ones_neg_half", ones, 14, 18);
        check("f6_underrun_n", u_n, 0);

        // F7/F8: full-scale positive -> all ones, i2 pinned, not wrapped
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check("f7_underrun_n", u_n, 1);
        run_frame(0, ones, s_at, s_n, u_at, u_n, rdy_low);
        check("f8_ones_full", ones, 64);
        check("f8_i2_sat", dut.i2, 524287);

        // drop en mid-frame
        for (int k = 0; k < 20; k++) tick();
        en = 1'b0;
        check("en_low_strobe", frame_strobe, 0);
        tick();
        check("idle_i1_clear", dut.i1, 0);
        check("idle_i2_clear", dut.i2, 0);
        b = bit_out;
        tick();
        check("idle_toggle_after_run", bit_out, {31'd0, ~b});

        // re-enable with empty buffer -> PRIME holds bit_out
        en = 1'b1;
        tick();
        b = bit_out;
        tick(); tick();
        check("prime_hold", bit_out, {31'd0, b});
        sif.sample_in = 16'sd0; sif.sample_valid = 1'b1;
        check("prime_ready", sif.sample_ready, 1);
        tick();
        sif.sample_valid = 1'b0;
        check("prime_buf_full", sif.sample_ready, 0);
        tick();                                  // PRIME -> RUN
        check("restart_hold", bit_out, {31'd0, b});
        check("restart_ready", sif.sample_ready, 1);
        check("restart_i1", dut.i1, 0);
        check("restart_i2", dut.i2, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("restart_bit_%0d", k), bit_out, zbits[k]);
            check($sformatf("restart_i2_%0d", k), dut.i2, zi2[k]);
        end

        // asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bit", bit_out, 0);
        check("async_rst_i2", dut.i2, 0);
        check("async_rst_ready", sif.sample_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
